clkdiv_prog: RTL and testbench

- Multi-channel programmable clock-enable divider. Each channel produces a divided square wave dclk_o, plus single-cycle strobes at the divided period and at its rising edge. The divide ratio is runtime-programmable per channel.
- A new ratio is committed only at a period boundary, so the divided output never produces a runt pulse.
- Sits between the system clock and slow peripherals (blinkers, scan, baud ticks) and replaces the fixed power-of-two counter-tap selection.
- All outputs are synchronous to clk_i. No generated clocks.

---
 rtl/clkdiv_prog.sv | 115 +++++++++++
 tb/tb_clkdiv_prog.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_prog.sv
// Multi-channel programmable clock-enable divider: per-channel divided square wave
// with fall/rise strobes; new divisors commit only at a period boundary.
module clkdiv_prog #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned W       = 16,
  parameter int unsigned DEF_DIV = 256
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [NCH-1:0]   en_i,
  input  logic             sync_i,
  input  logic [NCH-1:0]   load_i,
  input  logic [NCH*W-1:0] div_i,
  output logic [NCH-1:0]   busy_o,
  output logic [NCH-1:0]   dclk_o,
  output logic [NCH-1:0]   tick_o,
  output logic [NCH-1:0]   rise_o
);

  localparam logic [W-1:0] DEF_D = W'(DEF_DIV);

  logic [NCH-1:0][W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][W-1:0] act_q, act_d;
  logic [NCH-1:0][W-1:0] pend_q, pend_d;
  logic [NCH-1:0]        busy_q, busy_d;
  logic [NCH-1:0]        dclk_q, dclk_d;
  logic [NCH-1:0]        tick_q, tick_d;
  logic [NCH-1:0]        rise_q, rise_d;

  function automatic logic [W-1:0] clamp2(input logic [W-1:0] v);
    return (v < W'(2)) ? W'(2) : v;
  endfunction

  // Per-channel next state: sync beats load-while-idle beats normal counting.
  always_comb begin
    logic [W-1:0] div_c;
    logic [W-1:0] cnt_nxt;
    logic [W-1:0] act_n;
    logic         wrap;
    logic         dclk_n;
    cnt_d  = cnt_q;
    act_d  = act_q;
    pend_d = pend_q;
    busy_d = busy_q;
    dclk_d = dclk_q;
    tick_d = '0;
    rise_d = '0;
    for (int c = 0; c < NCH; c++) begin
      div_c   = clamp2(div_i[c*W +: W]);
      wrap    = (cnt_q[c] == act_q[c] - W'(1));
      cnt_nxt = wrap ? '0 : cnt_q[c] + W'(1);
      act_n   = act_q[c];
      dclk_n  = dclk_q[c];
      if (sync_i) begin
        cnt_d[c]  = '0;
        dclk_d[c] = 1'b0;
        busy_d[c] = 1'b0;
        if (load_i[c]) begin
          act_d[c]  = div_c;
          pend_d[c] = div_c;
        end else if (busy_q[c]) begin
          act_d[c] = pend_q[c];
        end
      end else if (load_i[c] && !en_i[c]) begin
        act_d[c]  = div_c;
        pend_d[c] = div_c;
        cnt_d[c]  = '0;
        dclk_d[c] = 1'b0;
        busy_d[c] = 1'b0;
      end else if (en_i[c]) begin
        if (load_i[c]) pend_d[c] = div_c;
        if (wrap) begin
          // A load landing on the wrap edge commits directly.
          if (load_i[c])      act_n = div_c;
          else if (busy_q[c]) act_n = pend_q[c];
          busy_d[c] = 1'b0;
        end else begin
          busy_d[c] = busy_q[c] | load_i[c];
        end
        dclk_n    = (cnt_nxt >= (act_n >> 1));
        act_d[c]  = act_n;
        cnt_d[c]  = cnt_nxt;
        dclk_d[c] = dclk_n;
        tick_d[c] = wrap;
        rise_d[c] = !dclk_q[c] && dclk_n;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q  <= '0;
      act_q  <= {NCH{DEF_D}};
      pend_q <= {NCH{DEF_D}};
      busy_q <= '0;
      dclk_q <= '0;
      tick_q <= '0;
      rise_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      dclk_q <= dclk_d;
      tick_q <= tick_d;
      rise_q <= rise_d;
    end
  end

  assign busy_o = busy_q;
  assign dclk_o = dclk_q;
  assign tick_o = tick_q;
  assign rise_o = rise_q;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed bench for clkdiv_prog with hand-computed waveforms per channel.
module tb_clkdiv_prog;

  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 16;

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic [NCH-1:0]   en_i;
  logic             sync_i;
  logic [NCH-1:0]   load_i;
  logic [NCH*W-1:0] div_i;
  logic [NCH-1:0]   busy_o, dclk_o, tick_o, rise_o;

  int n_assert = 0;
  int n_fail   = 0;

  clkdiv_prog #(.NCH(NCH), .W(W), .DEF_DIV(256)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .en_i   (en_i),
    .sync_i (sync_i),
    .load_i (load_i),
    .div_i  (div_i),
    .busy_o (busy_o),
    .dclk_o (dclk_o),
    .tick_o (tick_o),
    .rise_o (rise_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic check(input string tag, input int idx, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  function automatic logic bit_at(input string s, input int i);
    return s[i] == "1";
  endfunction

  task automatic set_div(input int c, input logic [W-1:0] v);
    div_i[c*W +: W] = v;
  endtask

  string t3_dclk, t3_tick, t3_rise, t3_busy;

  initial begin
    rstn_i = 1'b0;
    en_i   = '0;
    sync_i = 1'b0;
    load_i = '0;
    div_i  = '0;
    step(2);
    check("rst_dclk", 0, 16'(dclk_o), 16'h0);
    check("rst_busy", 0, 16'(busy_o), 16'h0);
    check("rst_tick", 0, 16'(tick_o | rise_o), 16'h0);

    // Default divisor 256 on all channels
    rstn_i = 1'b1;
    en_i   = '1;
    step(127);
    check("def_dclk127", 127, 16'(dclk_o), 16'h0);
    step(1);
    check("def_dclk128", 128, 16'(dclk_o), 16'hF);
    check("def_rise128", 128, 16'(rise_o), 16'hF);
    step(127);
    check("def_tick255", 255, 16'(tick_o), 16'h0);
    step(1);
    check("def_tick256", 256, 16'(tick_o), 16'hF);
    check("def_dclk256", 256, 16'(dclk_o), 16'h0);

    // Ch0: load 5 while disabled, then run
    en_i = 4'b1110; load_i = 4'b0001; set_div(0, 16'd5);
    step(1);
    check("c0_load_dclk", 0, 16'(dclk_o[0]), 16'h0);
    check("c0_load_busy", 0, 16'(busy_o[0]), 16'h0);
    en_i = '1; load_i = '0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      check("c0_dclk", i, 16'(dclk_o[0]), 16'(bit_at("0111001110", i-1)));
      check("c0_tick", i, 16'(tick_o[0]), 16'(bit_at("0000100001", i-1)));
      check("c0_rise", i, 16'(rise_o[0]), 16'(bit_at("0100001000", i-1)));
    end

    // Ch1: D=10, load 4 mid-period, then 7 and 12 within one period
    en_i = 4'b1101; load_i = 4'b0010; set_div(1, 16'd10);
    step(1);
    en_i = '1; load_i = '0;
    t3_dclk = {"00001111100110", "0110000001111110"};
    t3_tick = {"00000000010001", "0001000000000001"};
    t3_rise = {"00001000000100", "0100000001000000"};
    t3_busy = {"00011111100000", "1110000000000000"};
    for (int i = 1; i <= 30; i++) begin
      load_i[1] = (i == 4) || (i == 15) || (i == 16);
      set_div(1, (i == 4) ? 16'd4 : (i == 15) ? 16'd7 : 16'd12);
      step(1);
      check("c1_dclk", i, 16'(dclk_o[1]), 16'(bit_at(t3_dclk, i-1)));
      check("c1_tick", i, 16'(tick_o[1]), 16'(bit_at(t3_tick, i-1)));
      check("c1_rise", i, 16'(rise_o[1]), 16'(bit_at(t3_rise, i-1)));
      check("c1_busy", i, 16'(busy_o[1]), 16'(bit_at(t3_busy, i-1)));
    end
    load_i = '0;

    // Ch2: divisors 0 and 1 clamp to 2
    en_i = 4'b1011; load_i = 4'b0100; set_div(2, 16'd0);
    step(1);
    check("c2_clamp_dclk", 0, 16'(dclk_o[2]), 16'h0);
    en_i = '1; load_i = '0; set_div(2, 16'd1);
    for (int i = 1; i <= 8; i++) begin
      load_i[2] = (i == 5);
      step(1);
      check("c2_dclk", i, 16'(dclk_o[2]), 16'(bit_at("10101010", i-1)));
      check("c2_tick", i, 16'(tick_o[2]), 16'(bit_at("01010101", i-1)));
      check("c2_rise", i, 16'(rise_o[2]), 16'(bit_at("10101010", i-1)));
      check("c2_busy", i, 16'(busy_o[2]), 16'(bit_at("00001000", i-1)));
    end
    load_i = '0;

    // Ch2: D=8, enable dropped for 7 cycles in the high phase
    en_i = 4'b1011; load_i = 4'b0100; set_div(2, 16'd8);
    step(1);
    load_i = '0;
    for (int i = 1; i <= 15; i++) begin
      en_i[2] = !(i >= 6 && i <= 12);
      step(1);
      check("c2_hold_dclk", i, 16'(dclk_o[2]), 16'(bit_at("000111111111110", i-1)));
      check("c2_hold_tick", i, 16'(tick_o[2]), 16'(bit_at("000000000000001", i-1)));
      check("c2_hold_rise", i, 16'(rise_o[2]), 16'(bit_at("000100000000000", i-1)));
    end

    // Sync with ch1 pending 9 and ch0 loading 6 on the sync edge
    en_i = '1;
    step(7);
    load_i = 4'b0010; set_div(1, 16'd9);
    step(1);
    sync_i = 1'b1; load_i = 4'b0001; set_div(0, 16'd6);
    step(1);
    sync_i = 1'b0; load_i = '0;
    check("sync_dclk", 0, 16'(dclk_o), 16'h0);
    check("sync_busy", 0, 16'(busy_o), 16'h0);
    check("sync_strb", 0, 16'(tick_o | rise_o), 16'h0);
    for (int i = 1; i <= 18; i++) begin
      step(1);
      check("sync_tick", i, 16'(tick_o),
            16'({1'b0, (i % 8) == 0, (i % 9) == 0, (i % 6) == 0}));
      check("sync_dclk01", i, 16'(dclk_o[1:0]), 16'({(i % 9) >= 4, (i % 6) >= 3}));
    end

    // Pending load on ch3, then async reset mid-period
    load_i = 4'b1000; set_div(3, 16'd20);
    step(1);
    load_i = '0;
    check("c3_busy", 19, 16'(busy_o[3]), 16'h1);
    step(1);
    check("pre_rst_dclk2", 20, 16'(dclk_o[2]), 16'h1);
    #2 rstn_i = 1'b0;
    #1;
    check("arst_dclk", 0, 16'(dclk_o), 16'h0);
    check("arst_busy", 0, 16'(busy_o), 16'h0);
    check("arst_strb", 0, 16'(tick_o | rise_o), 16'h0);
    step(1);
    rstn_i = 1'b1; en_i = '1;
    step(20);
    check("post_rst_tick20", 20, 16'(tick_o), 16'h0);
    step(107);
    check("post_rst_dclk127", 127, 16'(dclk_o), 16'h0);
    step(1);
    check("post_rst_rise128", 128, 16'(rise_o), 16'hF);
    check("post_rst_dclk128", 128, 16'(dclk_o), 16'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
